// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: receive-only I2C slave that matches a 7-bit address and recovers written bytes.
// Ports:
//   clk_i       system clock, all logic on its rising edge
//   reset_ni    asynchronous active-low reset
//   scl_i       raw SCL line, asynchronous to clk_i
//   sda_i       raw SDA line, asynchronous to clk_i
//   sda_oe_o    1 = pull SDA low (ACK), 0 = release
//   rx_data_o   last completed data byte
//   rx_valid_o  one-cycle strobe when rx_data_o is updated
//   rx_rw_o     R/W bit of the last matched address byte
//   busy_o      high from START until STOP or address mismatch
//   state_o     current FSM state (debug)
//   count_o     bits received in the current byte, 0..8
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h2A
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_rw_o,
    output logic       busy_o,
    output logic [2:0] state_o,
    output logic [3:0] count_o
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        DATA     = 3'd3,
        DATA_ACK = 3'd4,
        IGNORE   = 3'd5
    } state_e;
    state_e     state_q, state_d;
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_d_q, sda_d_q;
    logic [3:0] count_q, count_d, count_inc;
    logic [7:0] shift_q, shift_d, shift_in, rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d, rx_rw_q, rx_rw_d;
    logic       busy_q, busy_d, sda_oe_q, sda_oe_d;
    logic       scl_s, sda_s, scl_rise, scl_fall, start, stop;
    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_d_q;
    assign scl_fall  = ~scl_s & scl_d_q;
    // SCL must be high on both taps so an SDA move coincident with an SCL edge is a data bit
    assign start     = scl_s & scl_d_q & sda_d_q & ~sda_s;
    assign stop      = scl_s & scl_d_q & ~sda_d_q & sda_s;
    assign shift_in  = {shift_q[6:0], sda_s};
    assign count_inc = (count_q == 4'd8) ? 4'd8 : count_q + 4'd1;
    // lines idle high, so the conditioning flops reset to 1 to avoid a false event
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_d_q    <= 1'b1;
            sda_d_q    <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_d_q    <= scl_s;
            sda_d_q    <= sda_s;
        end
    end
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            count_q    <= 4'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_rw_q    <= 1'b0;
            busy_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_rw_q    <= rx_rw_d;
            busy_q     <= busy_d;
            sda_oe_q   <= sda_oe_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_rw_d    = rx_rw_q;
        busy_d     = busy_q;
        sda_oe_d   = sda_oe_q;
        if (stop) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
        end else if (start) begin
            state_d  = ADDR;
            count_d  = 4'd0;
            busy_d   = 1'b1;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ADDR, DATA: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        count_d = count_inc;
                        if (count_inc == 4'd8) begin
                            if (state_q == DATA) begin
                                rx_data_d  = shift_in;
                                rx_valid_d = 1'b1;
                                state_d    = DATA_ACK;
                            end else if (shift_in[7:1] == SLAVE_ADDR) begin
                                rx_rw_d = shift_in[0];
                                state_d = ADDR_ACK;
                            end else begin
                                state_d = IGNORE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                // sda_oe_q doubles as the phase flag: first fall drives ACK, second fall ends it
                ADDR_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = ~sda_oe_q;
                        if (sda_oe_q) begin
                            count_d = 4'd0;
                            state_d = DATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
    assign sda_oe_o   = sda_oe_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_rw_o    = rx_rw_q;
    assign busy_o     = busy_q;
    assign state_o    = state_q;
    assign count_o    = count_q;
endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb_i2c_slave_rx: randomized I2C master driving i2c_slave_rx, checked against a transaction-level model.
// Ports: none (self-contained bench).
module tb_i2c_slave_rx;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_line;
    logic       sda_oe_o, rx_valid_o, rx_rw_o, busy_o;
    logic [7:0] rx_data_o;
    logic [2:0] state_o;
    logic [3:0] count_o;
    int         checks = 0;
    int         failures = 0;
    int         wide = 0;
    logic       prev_valid = 1'b0;
    logic       exp_rw = 1'b0;
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    // open-drain bus: the slave pulling low wins over the master's released line
    assign sda_line = sda_drv & ~sda_oe_o;

    i2c_slave_rx dut (
        .clk_i(clk), .reset_ni(reset_n), .scl_i(scl), .sda_i(sda_line),
        .sda_oe_o(sda_oe_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .rx_rw_o(rx_rw_o), .busy_o(busy_o), .state_o(state_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid_o) begin
            obs_q.push_back(rx_data_o);
            if (prev_valid) wide++;
        end
        prev_valid = rx_valid_o;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_start();
        sda_drv = 1'b1;
        wait_clk(3);
        scl = 1'b1;
        wait_clk(5);
        sda_drv = 1'b0;
        wait_clk(5);
        scl = 1'b0;
        wait_clk(3);
    endtask

    task automatic send_stop();
        sda_drv = 1'b0;
        wait_clk(3);
        scl = 1'b1;
        wait_clk(5);
        sda_drv = 1'b1;
        wait_clk(5);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        sda_drv = glitch ? ~b : b;
        wait_clk(3);
        sda_drv = b;
        scl = 1'b1;
        wait_clk(6);
        scl = 1'b0;
        wait_clk(3);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit glitch, output logic ack, output logic [3:0] cnt);
        for (int i = 7; i >= 0; i--) send_bit(b[i], glitch);
        sda_drv = 1'b1;
        wait_clk(3);
        scl = 1'b1;
        wait_clk(3);
        ack = sda_oe_o;
        cnt = count_o;
        wait_clk(3);
        scl = 1'b0;
        wait_clk(3);
        chk("ack_release", sda_oe_o, 0);
    endtask

    task automatic load(input int n, input logic [31:0] v);
        tx_q.delete();
        for (int i = n - 1; i >= 0; i--) tx_q.push_back(v[i*8 +: 8]);
    endtask

    // model: bytes are delivered and ACKed only when the address byte's upper 7 bits match 0x2A
    task automatic transaction(input logic [7:0] addr, input bit do_stop, input bit glitch);
        logic       ack;
        logic [3:0] cnt;
        logic       hit;
        hit = (addr[7:1] == 7'h2A);
        send_start();
        chk("busy_start", busy_o, 1);
        send_byte(addr, 1'b0, ack, cnt);
        chk("addr_ack", ack, hit);
        if (hit) begin
            exp_rw = addr[0];
            chk("ack_count", cnt, 8);
            chk("state_data", state_o, 3);
        end else begin
            chk("state_ignore", state_o, 5);
            chk("busy_ignore", busy_o, 0);
        end
        chk("rx_rw", rx_rw_o, exp_rw);
        foreach (tx_q[i]) begin
            send_byte(tx_q[i], glitch, ack, cnt);
            chk("data_ack", ack, hit);
            if (hit) exp_q.push_back(tx_q[i]);
        end
        if (do_stop) begin
            send_stop();
            chk("stop_state", state_o, 0);
            chk("stop_busy", busy_o, 0);
        end
    endtask

    task automatic drain(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) chk({tag, "_data"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] addr;
        for (int i = 0; i < 20; i++) begin
            scl = 1'($urandom);
            sda_drv = 1'($urandom);
            wait_clk(1);
        end
        chk("rst_oe", sda_oe_o, 0);
        chk("rst_data", rx_data_o, 0);
        chk("rst_valid", rx_valid_o, 0);
        chk("rst_rw", rx_rw_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_state", state_o, 0);
        chk("rst_count", count_o, 0);
        scl = 1'b1;
        sda_drv = 1'b1;
        wait_clk(2);
        reset_n = 1'b1;
        wait_clk(6);
        chk("post_rst_state", state_o, 0);

        load(1, 32'hA5);
        transaction(8'h54, 1'b1, 1'b0);
        drain("write");

        load(1, 32'h77);
        transaction(8'h56, 1'b1, 1'b0);
        drain("mismatch");

        load(3, 32'h00FF3C);
        transaction(8'h54, 1'b0, 1'b0);
        tx_q.delete();
        transaction(8'h55, 1'b1, 1'b0);
        drain("multi");

        load(0, 32'h0);
        transaction(8'h54, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b0);
        chk("abort_count", count_o, 4);
        send_stop();
        chk("abort_state", state_o, 0);
        drain("abort");

        load(2, $urandom);
        transaction(8'h54, 1'b1, 1'b1);
        drain("glitch");

        for (int t = 0; t < 8; t++) begin
            addr = $urandom_range(0, 1) ? {7'h2A, 1'($urandom)} : 8'($urandom);
            load($urandom_range(0, 3), $urandom);
            transaction(addr, (t == 7) || ($urandom_range(0, 1) == 1), 1'($urandom));
        end
        drain("random");

        send_start();
        for (int i = 7; i >= 0; i--) send_bit(1'((8'h54 >> i) & 8'h1), 1'b0);
        sda_drv = 1'b1;
        wait_clk(3);
        chk("ack_before_rst", sda_oe_o, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("ack_rst_oe", sda_oe_o, 0);
        chk("ack_rst_state", state_o, 0);
        chk("ack_rst_busy", busy_o, 0);
        scl = 1'b1;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(6);
        chk("ack_rst_idle", state_o, 0);
        drain("rst_ack");
        chk("valid_width", wide, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_slave_rx.md
# i2c_slave_rx

Receive-side I2C stage that consumes the SCL/SDA lines driven by the team's I2C master and recovers the transmitted bytes. It oversamples SCL/SDA with the system clock, detects START/STOP conditions, matches a 7-bit address, shifts in data bytes MSB-first and drives the ACK bit. Recovered bytes are presented as a one-cycle-valid parallel word to downstream logic on the Spartan 6 board.

## Interface

- SLAVE_ADDR, 7'h2A, 7-bit address this block acknowledges.
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- scl_in  input  1  raw SCL line; asynchronous to clk.
- sda_in  input  1  raw SDA line; asynchronous to clk.
- sda_oe  output  1  1 = pull SDA low (ACK); 0 = release. Reset 0.
- rx_data  output  8  last completed data byte. Reset 8'h00.
- rx_valid  output  1  one-cycle pulse, rx_data updated. Reset 0.
- rx_rw  output  1  R/W bit of the last matched address byte. Reset 0.
- busy  output  1  1 from START until STOP or address mismatch. Reset 0.
- state  output  3  current FSM state, debug. Reset IDLE.
- count  output  4  bits received in the current byte, 0..8. Reset 0.

## Operation

- Input conditioning: scl_in, sda_in each pass through two flops (scl_s, sda_s), then one delay flop (scl_d, sda_d). Synchronizer and delay flops reset to 1.
- Events (combinational from the conditioned signals): scl_rise = scl_s & ~scl_d; scl_fall = ~scl_s & scl_d; start = scl_s & scl_d & sda_d & ~sda_s; stop = scl_s & scl_d & ~sda_d & sda_s.
- States (encoding): IDLE=0, ADDR=1, ADDR_ACK=2, DATA=3, DATA_ACK=4, IGNORE=5.
- Priority: stop > start > scl edges. stop in any state -> IDLE, busy=0, sda_oe=0. start in any state (including repeated START) -> ADDR, count=0, busy=1, sda_oe=0.
- IDLE: waits for start only; scl edges ignored.
- ADDR: on scl_rise, shift sda_s into shift register LSB (MSB-first); count+1. When count reaches 8:
  - If shift[7:1] == SLAVE_ADDR, latch rx_rw = shift[0] and go to ADDR_ACK.
  - Otherwise go to IGNORE, busy=0.
- ADDR_ACK / DATA_ACK:
  - sda_oe set to 1 on the first scl_fall after entry.
  - sda_oe cleared on the next scl_fall (end of 9th clock); count=0; then go to DATA.
- DATA: shift as in ADDR. On the scl_rise completing bit 8, rx_data <= full byte and rx_valid=1 for exactly one cycle; then go to DATA_ACK. Every byte is ACKed; there is no backpressure.
- rx_rw=1 (master read) is recorded only; this block never transmits data and behaves as in the write case.
- IGNORE: sda_oe=0; waits for start or stop.
- count saturates at 8 and never wraps. The shift register is 8 bits, and the new bit enters the LSB.
- Async reset mid-transfer: all outputs and the FSM return to reset values immediately. SDA is released. The in-flight byte is discarded with no rx_valid.

## Timing

- Event latency: a raw line change first sampled at clk edge k is visible on scl_s/sda_s after edge k+1. The event is then acted on at edge k+2.
- rx_valid goes high 2 cycles after the edge that first samples the 8th SCL rise, and stays high for 1 cycle.
- sda_oe asserts 2 cycles after the edge that first samples the 8th SCL fall. It deasserts 2 cycles after the edge that first samples the 9th SCL fall.
- Minimum SCL high and low time is 4 clk cycles. SDA must be stable at least 3 clk cycles around each SCL edge. Shorter pulses are not guaranteed to be detected.
- The START/STOP checks require SCL high on both scl_s and scl_d. An SDA change coincident with an SCL edge is therefore not a START or STOP.

## Test plan

- Reset: hold reset=0 with lines toggling -> all outputs at reset values and state=0. Release reset -> state remains IDLE.
- Matched write: START, address 0x54 (7'h2A, W), then byte 0xA5, then STOP.
  - sda_oe pulses during both 9th clocks.
  - rx_valid pulses once with rx_data=0xA5; rx_rw=0.
  - After STOP: busy=0, state=IDLE.
- Address mismatch: START, then 0x56 -> no sda_oe, state=IGNORE, busy=0. A following byte produces no rx_valid.
- Multi-byte and repeated START:
  - Bytes 0x00, 0xFF, 0x3C -> three rx_valid pulses in order.
  - Repeated START, then 0x55 (read) -> ACK and rx_rw=1.
- Abort: STOP after 4 data bits -> IDLE with no rx_valid. Separately, reset=0 during the ACK bit -> sda_oe drops immediately.
- Glitch: SDA changes at the same clk edge as an SCL rise -> no START/STOP detected, and the bit is sampled as the new value.
